memory_access: RTL and testbench
================================

# memory_access

Memory stage of the MIPS datapath, directly downstream of the Execute stage. Consumes the ALU result as an effective address and the second register operand as store data. Performs word, halfword and byte loads and stores against an internal little-endian data memory. Registers the result, together with the write-back control, for the write-back stage; this gives one cycle of latency, with stall and misalignment handling.

## Interface
Parameters:
- DEPTH_WORDS, 256: data memory depth in 32-bit words; power of two, at least 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold all output registers; suppress the memory write.
- valid_in  in  1  the instruction at the inputs is real. When 0, nothing is written to memory and a bubble is produced.
- ALUResult  in  32  effective byte address from Execute.
- ALUReadData2  in  32  store data; the low bits are used for sb and sh.
- mem_read  in  1  load instruction.
- mem_write  in  1  store instruction. mem_read and mem_write are never both 1; if they are, the access is treated as a store.
- mem_size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is treated as word.
- mem_unsigned  in  1  loads only: 1 zero-extends (lbu, lhu), 0 sign-extends.
- reg_write_in  in  1  write-back enable from decode.
- write_reg_in  in  5  destination register number.
- valid_out  out  1  the output registers hold a real instruction.
- wb_data  out  32  extended load data for loads; ALUResult for everything else.
- reg_write_out  out  1  write-back enable, forced to 0 on a misaligned access.
- write_reg_out  out  5  destination register number.
- misaligned  out  1  one-cycle flag marking that the registered access was misaligned.

## Operation
- Word index: ALUResult[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Byte lane: ALUResult[1:0]. Lane 0 is bits [7:0], lane 3 is bits [31:24].
- Alignment rules:
  - A halfword access requires ALUResult[0]=0.
  - A word access requires ALUResult[1:0]=00.
  - A byte access is always aligned.
  - "bad" = valid_in & (mem_read|mem_write) & alignment violated.
- Store (valid_in & mem_write & !bad & !stall & !reset):
  - Writes only the selected lanes at the clock edge: sb 1 lane, sh 2 lanes, sw 4.
  - Lanes not selected keep their value.
- Load data path:
  - The word is read combinationally from the array.
  - The lane or lanes are selected, then sign- or zero-extended to 32 bits.
  - The result is registered into wb_data.
- Non-memory instructions pass ALUResult through to wb_data.
- Misaligned access:
  - No memory write.
  - misaligned=1, reg_write_out=0 and valid_out=valid_in.
  - wb_data holds ALUResult.
- Bubble (valid_in=0):
  - valid_out=0, reg_write_out=0, misaligned=0.
  - wb_data and write_reg_out are still loaded, and their value is don't-care.
- Stall: every output register and the memory array keep their value, including misaligned.
- Memory contents are not affected by reset; they are undefined until written.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- Throughput is one access per cycle when stall=0.
- Store then load to the same word on consecutive cycles: the load returns the new data, because the write completes at the earlier edge. No bypass is needed.
- Reset: while reset=1 at an edge, the outputs clear and memory is not written. Reset values:
  - valid_out=0, wb_data=0, reg_write_out=0, write_reg_out=0, misaligned=0.
  - Reset takes priority over stall.
- Reset asserted in the same cycle as a store: the store is dropped.
- stall and reset are both 0 and valid_in=1: the outputs always update, whatever the access type.

## Test plan
- Store/load word: sw 0xDEADBEEF to addr 0x10, then the next cycle lw 0x10. wb_data=0xDEADBEEF one cycle after the lw, and reg_write_out=1.
- Bytes: sb 0x80 to 0x13, then lb 0x13 and lbu 0x13. Required results:
  - lb gives wb_data=0xFFFFFF80 and lbu gives 0x00000080.
  - A following lw 0x10 gives 0x80ADBEEF.
- Halfword and misalignment:
  - sh 0x1234 to 0x22, then lhu 0x22, gives wb_data=0x00001234.
  - sh to 0x21 gives misaligned=1 and reg_write_out=0, and leaves memory unchanged; check this with lw 0x20.
- Stall: hold stall=1 for 3 cycles while presenting sw 0x55 to 0x40. The outputs stay frozen. A later lw 0x40 does not return 0x55 unless the store was re-presented with stall=0.
- Reset mid-stream: assert reset in the cycle a sw 0xAAAAAAAA to 0x30 is presented. After the edge all outputs are 0, and lw 0x30 returns the value it held before.
- Wrap: with DEPTH_WORDS=256, sw 0x1 to 0x400 and then lw 0x0. wb_data=0x00000001.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage of the MIPS datapath: little-endian byte/halfword/word loads and
// stores against an internal data memory, with one registered output stage
// feeding write-back. Misaligned accesses are flagged and suppressed, stall
// freezes the outputs and blocks the memory write.
module memory_access #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        valid_in,
   input  logic [31:0] ALUResult,
   input  logic [31:0] ALUReadData2,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic        reg_write_in,
   input  logic [4:0]  write_reg_in,
   output logic        valid_out,
   output logic [31:0] wb_data,
   output logic        reg_write_out,
   output logic [4:0]  write_reg_out,
   output logic        misaligned
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0] mem_array [DEPTH_WORDS];

   logic [AW-1:0] word_idx;
   logic [1:0]    lane;
   logic          size_byte;
   logic          size_half;
   logic          size_word;
   logic          is_store;
   logic          is_load;
   logic          align_err;
   logic          bad;
   logic          do_write;
   logic [3:0]    byte_en;
   logic [31:0]   store_word;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   load_ext;

   // Address bits above the memory window are deliberately ignored so that
   // addresses wrap around the array.
   logic unused_addr_bits;
   assign unused_addr_bits = ^ALUResult[31:AW+2];

   logic        valid_d,     valid_q;
   logic [31:0] wb_data_d,   wb_data_q;
   logic        reg_write_d, reg_write_q;
   logic [4:0]  write_reg_d, write_reg_q;
   logic        mis_d,       mis_q;

   // Decode the access, check alignment and build lane enables and store data.
   always_comb begin
      word_idx   = ALUResult[AW+1:2];
      lane       = ALUResult[1:0];
      size_byte  = (mem_size == 2'b00);
      size_half  = (mem_size == 2'b01);
      size_word  = ~size_byte & ~size_half;
      is_store   = mem_write;
      is_load    = mem_read & ~mem_write;
      align_err  = (size_half & lane[0]) | (size_word & (|lane));
      bad        = valid_in & (mem_read | mem_write) & align_err;
      do_write   = valid_in & is_store & ~bad & ~stall & ~reset;
      byte_en    = 4'b1111;
      store_word = ALUReadData2;
      if (size_byte) begin
         byte_en    = 4'b0001 << lane;
         store_word = {4{ALUReadData2[7:0]}};
      end else if (size_half) begin
         byte_en    = lane[1] ? 4'b1100 : 4'b0011;
         store_word = {2{ALUReadData2[15:0]}};
      end
   end

   // Read the addressed word, align the selected lane(s) down and extend.
   always_comb begin
      rd_word  = mem_array[word_idx];
      rd_shift = rd_word >> {lane, 3'b000};
      load_ext = rd_shift;
      if (size_byte) begin
         load_ext = {{24{rd_shift[7] & ~mem_unsigned}}, rd_shift[7:0]};
      end else if (size_half) begin
         load_ext = {{16{rd_shift[15] & ~mem_unsigned}}, rd_shift[15:0]};
      end
   end

   // Next values of the output registers; a stall simply holds them.
   always_comb begin
      valid_d     = valid_q;
      wb_data_d   = wb_data_q;
      reg_write_d = reg_write_q;
      write_reg_d = write_reg_q;
      mis_d       = mis_q;
      if (!stall) begin
         valid_d     = valid_in;
         mis_d       = bad;
         reg_write_d = valid_in & reg_write_in & ~bad;
         write_reg_d = write_reg_in;
         wb_data_d   = (valid_in & is_load & ~bad) ? load_ext : ALUResult;
      end
   end

   // Output register stage; reset wins over stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         wb_data_q   <= 32'd0;
         reg_write_q <= 1'b0;
         write_reg_q <= 5'd0;
         mis_q       <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         wb_data_q   <= wb_data_d;
         reg_write_q <= reg_write_d;
         write_reg_q <= write_reg_d;
         mis_q       <= mis_d;
      end
   end

   // Byte-lane write into the data memory; contents are never reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (do_write && byte_en[i]) begin
            mem_array[word_idx][8*i +: 8] <= store_word[8*i +: 8];
         end
      end
   end

   assign valid_out     = valid_q;
   assign wb_data       = wb_data_q;
   assign reg_write_out = reg_write_q;
   assign write_reg_out = write_reg_q;
   assign misaligned    = mis_q;

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios followed by random
// traffic, all compared against a byte-array reference model of the stage.
module tb_memory_access;

   localparam int DEPTH = 256;
   localparam int BYTES = 4 * DEPTH;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        valid_in;
   logic [31:0] ALUResult;
   logic [31:0] ALUReadData2;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic        reg_write_in;
   logic [4:0]  write_reg_in;
   logic        valid_out;
   logic [31:0] wb_data;
   logic        reg_write_out;
   logic [4:0]  write_reg_out;
   logic        misaligned;

   int checks = 0;
   int errors = 0;

   logic [7:0]  model_mem [BYTES];
   logic        exp_valid;
   logic [31:0] exp_wb;
   logic        exp_rw;
   logic [4:0]  exp_wr;
   logic        exp_mis;
   logic        exp_data_known;

   memory_access #(.DEPTH_WORDS(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .stall(stall),
      .valid_in(valid_in),
      .ALUResult(ALUResult),
      .ALUReadData2(ALUReadData2),
      .mem_read(mem_read),
      .mem_write(mem_write),
      .mem_size(mem_size),
      .mem_unsigned(mem_unsigned),
      .reg_write_in(reg_write_in),
      .write_reg_in(write_reg_in),
      .valid_out(valid_out),
      .wb_data(wb_data),
      .reg_write_out(reg_write_out),
      .write_reg_out(write_reg_out),
      .misaligned(misaligned)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single point of comparison for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Little-endian read of n bytes from the model, then extension to 32 bits.
   function automatic logic [31:0] modelLoad(input int unsigned a, input int n, input logic uns);
      logic [63:0] val;
      val = 64'd0;
      for (int k = 0; k < n; k++) begin
         val = val | (64'(model_mem[(a + k) % BYTES]) << (8 * k));
      end
      if (!uns && n < 4 && val[8*n-1]) begin
         val = val | (~64'd0 << (8 * n));
      end
      return val[31:0];
   endfunction

   // Drive one cycle of inputs, advance the model, clock, and compare outputs.
   task automatic applyStimulus(input logic rst, input logic st, input logic v,
                                input logic [31:0] addr, input logic [31:0] data,
                                input logic rd, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic rwi, input logic [4:0] wri);
      int unsigned a;
      int          n;
      logic        mis;
      reset = rst; stall = st; valid_in = v; ALUResult = addr; ALUReadData2 = data;
      mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      reg_write_in = rwi; write_reg_in = wri;

      a   = addr % BYTES;
      n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = v && (rd || wr) && ((a % n) != 0);
      if (rst) begin
         exp_valid = 0; exp_wb = 0; exp_rw = 0; exp_wr = 0; exp_mis = 0; exp_data_known = 1;
      end else if (!st) begin
         exp_valid      = v;
         exp_mis        = mis;
         exp_rw         = v && rwi && !mis;
         exp_wr         = wri;
         exp_data_known = v;
         exp_wb         = (v && rd && !wr && !mis) ? modelLoad(a, n, uns) : addr;
         if (v && wr && !mis) begin
            for (int k = 0; k < n; k++) model_mem[a + k] = data[8*k +: 8];
         end
      end

      @(posedge clk);
      #1;
      checkOutput("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
      checkOutput("reg_write_out", {31'd0, reg_write_out}, {31'd0, exp_rw});
      checkOutput("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
      if (exp_data_known) begin
         checkOutput("wb_data", wb_data, exp_wb);
         checkOutput("write_reg_out", {27'd0, write_reg_out}, {27'd0, exp_wr});
      end
   endtask

   // Convenience wrappers for the common instruction shapes.
   task automatic doStore(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] sz);
      applyStimulus(0, 0, 1, addr, data, 0, 1, sz, 0, 0, 5'd0);
   endtask

   task automatic doLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
      applyStimulus(0, 0, 1, addr, 32'h0, 1, 0, sz, uns, 1, 5'd7);
   endtask

   // Directed scenarios, then randomized traffic.
   initial begin
      logic [31:0] saved;
      logic [31:0] r;
      for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;

      applyStimulus(1, 0, 0, 32'h0, 32'h0, 0, 0, 2'd0, 0, 0, 5'd0);
      applyStimulus(1, 1, 1, 32'h1234, 32'h0, 0, 0, 2'd2, 0, 1, 5'd3);
      checkOutput("reset_wb", wb_data, 32'h0);

      for (int i = 0; i < DEPTH; i++) doStore(32'(4 * i), $urandom, 2'd2);

      doStore(32'h10, 32'hDEADBEEF, 2'd2);
      doLoad(32'h10, 2'd2, 0);
      checkOutput("lw_deadbeef", wb_data, 32'hDEADBEEF);
      checkOutput("lw_regwrite", {31'd0, reg_write_out}, 32'd1);

      doStore(32'h13, 32'h00000080, 2'd0);
      doLoad(32'h13, 2'd0, 0);
      checkOutput("lb_sign", wb_data, 32'hFFFFFF80);
      doLoad(32'h13, 2'd0, 1);
      checkOutput("lbu_zero", wb_data, 32'h00000080);
      doLoad(32'h10, 2'd2, 0);
      checkOutput("lw_after_sb", wb_data, 32'h80ADBEEF);

      doStore(32'h22, 32'h00001234, 2'd1);
      doLoad(32'h22, 2'd1, 1);
      checkOutput("lhu", wb_data, 32'h00001234);
      saved = modelLoad(32'h20, 4, 0);
      applyStimulus(0, 0, 1, 32'h21, 32'h00005678, 0, 1, 2'd1, 0, 1, 5'd9);
      checkOutput("sh_mis_flag", {31'd0, misaligned}, 32'd1);
      checkOutput("sh_mis_regwrite", {31'd0, reg_write_out}, 32'd0);
      checkOutput("sh_mis_wb", wb_data, 32'h21);
      doLoad(32'h20, 2'd2, 0);
      checkOutput("sh_mis_nowrite", wb_data, saved);

      saved = modelLoad(32'h40, 4, 0);
      if (saved == 32'h55) doStore(32'h40, 32'h0, 2'd2);
      saved = modelLoad(32'h40, 4, 0);
      r = wb_data;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 32'h40, 32'h55, 0, 1, 2'd2, 0, 1, 5'd4);
         checkOutput("stall_frozen", wb_data, r);
      end
      doLoad(32'h40, 2'd2, 0);
      checkOutput("stall_nowrite", wb_data, saved);

      saved = modelLoad(32'h30, 4, 0);
      applyStimulus(1, 0, 1, 32'h30, 32'hAAAAAAAA, 0, 1, 2'd2, 0, 1, 5'd5);
      checkOutput("rst_valid", {31'd0, valid_out}, 32'd0);
      checkOutput("rst_wb", wb_data, 32'd0);
      checkOutput("rst_wr", {27'd0, write_reg_out}, 32'd0);
      doLoad(32'h30, 2'd2, 0);
      checkOutput("rst_store_dropped", wb_data, saved);

      doStore(32'h400, 32'h1, 2'd2);
      doLoad(32'h0, 2'd2, 0);
      checkOutput("wrap", wb_data, 32'h00000001);

      for (int i = 0; i < 800; i++) begin
         logic [31:0] addr;
         int          op;
         op   = $urandom_range(0, 9);
         addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
         applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0,
                       $urandom_range(0, 7) != 0, addr, $urandom,
                       (op < 4) || (op == 9), (op >= 4 && op < 8) || (op == 9),
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
